// File: rtl/terminal_fifo.sv
// -----------------------------------------------------------------------------
// terminal_fifo
//
// Dual byte FIFO between the USB-CDC terminal core and the j1 IO bus, both in
// the 12 MHz application clock domain.
//   RX side: host-to-target bytes from the CDC out-stream, popped by CPU reads.
//   TX side: CPU-written bytes, drained by the CDC in-stream.
// Both FIFOs are first-word-fall-through. Full and empty come from the level
// counters only. Sticky error flags report CPU reads of an empty RX FIFO and
// CPU writes to a full TX FIFO.
//
// Ports:
//   clk, reset                   application clock, async active-high reset
//   usb_out_data/valid/ready     CDC out-stream into the RX FIFO
//   usb_in_data/valid/ready      TX FIFO head towards the CDC in-stream
//   cpu_rd, cpu_rx_data/valid    CPU pop strobe and RX head
//   cpu_wr, cpu_tx_data/ready    CPU push strobe and TX space indication
//   rx_level, tx_level           occupancy 0..DEPTH
//   err_clr                      clears both sticky flags (set wins)
//   rx_underrun, tx_overrun      sticky error flags
// -----------------------------------------------------------------------------
module terminal_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            usb_out_data,
    input  logic                  usb_out_valid,
    output logic                  usb_out_ready,
    output logic [7:0]            usb_in_data,
    output logic                  usb_in_valid,
    input  logic                  usb_in_ready,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_rx_data,
    output logic                  cpu_rx_valid,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_tx_data,
    output logic                  cpu_tx_ready,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic [DEPTH_LOG2:0]   tx_level,
    input  logic                  err_clr,
    output logic                  rx_underrun,
    output logic                  tx_overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]         LVL_ZERO = LW'(0);
    localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    // Storage (contents are deliberately not reset)
    logic [7:0]            rx_mem_r [DEPTH];
    logic [7:0]            tx_mem_r [DEPTH];

    logic [DEPTH_LOG2-1:0] rx_wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr_r;
    logic [LW-1:0]         rx_level_r;
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_r;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr_r;
    logic [LW-1:0]         tx_level_r;
    logic                  rx_underrun_r;
    logic                  tx_overrun_r;

    logic rx_full_s;
    logic rx_empty_s;
    logic tx_full_s;
    logic tx_empty_s;
    logic rx_push_s;
    logic rx_pop_s;
    logic tx_push_s;
    logic tx_pop_s;
    logic rx_underrun_set_s;
    logic tx_overrun_set_s;

    // Status decode from registered levels only, so ready/valid never depend
    // combinationally on the partner's valid/ready.
    assign rx_full_s  = (rx_level_r == LVL_FULL);
    assign rx_empty_s = (rx_level_r == LVL_ZERO);
    assign tx_full_s  = (tx_level_r == LVL_FULL);
    assign tx_empty_s = (tx_level_r == LVL_ZERO);

    assign usb_out_ready = ~rx_full_s;
    assign cpu_rx_valid  = ~rx_empty_s;
    assign cpu_tx_ready  = ~tx_full_s;
    assign usb_in_valid  = ~tx_empty_s;

    assign rx_push_s = usb_out_valid & usb_out_ready;
    assign rx_pop_s  = cpu_rd & cpu_rx_valid;
    assign tx_push_s = cpu_wr & cpu_tx_ready;
    assign tx_pop_s  = usb_in_valid & usb_in_ready;

    assign rx_underrun_set_s = cpu_rd & rx_empty_s;
    assign tx_overrun_set_s  = cpu_wr & tx_full_s;

    // Fall-through heads; the array may hold stale bytes, so gate on empty.
    assign cpu_rx_data = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r];
    assign usb_in_data = tx_empty_s ? 8'h00 : tx_mem_r[tx_rd_ptr_r];

    assign rx_level    = rx_level_r;
    assign tx_level    = tx_level_r;
    assign rx_underrun = rx_underrun_r;
    assign tx_overrun  = tx_overrun_r;

    // RX array write
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= usb_out_data;
        end
    end

    // TX array write
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= cpu_tx_data;
        end
    end

    // RX pointers and level counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            rx_level_r  <= '0;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            end else begin
                rx_wr_ptr_r <= rx_wr_ptr_r;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            end else begin
                rx_rd_ptr_r <= rx_rd_ptr_r;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_level_r <= rx_level_r + LVL_ONE;
                2'b01:   rx_level_r <= rx_level_r - LVL_ONE;
                default: rx_level_r <= rx_level_r;
            endcase
        end
    end

    // TX pointers and level counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            tx_level_r  <= '0;
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            end else begin
                tx_wr_ptr_r <= tx_wr_ptr_r;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end else begin
                tx_rd_ptr_r <= tx_rd_ptr_r;
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_level_r <= tx_level_r + LVL_ONE;
                2'b01:   tx_level_r <= tx_level_r - LVL_ONE;
                default: tx_level_r <= tx_level_r;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_underrun_r <= 1'b0;
            tx_overrun_r  <= 1'b0;
        end else begin
            if (rx_underrun_set_s) begin
                rx_underrun_r <= 1'b1;
            end else if (err_clr) begin
                rx_underrun_r <= 1'b0;
            end else begin
                rx_underrun_r <= rx_underrun_r;
            end
            if (tx_overrun_set_s) begin
                tx_overrun_r <= 1'b1;
            end else if (err_clr) begin
                tx_overrun_r <= 1'b0;
            end else begin
                tx_overrun_r <= tx_overrun_r;
            end
        end
    end

endmodule

// File: tb/tb_terminal_fifo.sv
// -----------------------------------------------------------------------------
// tb_terminal_fifo
//
// Directed bench for terminal_fifo (DEPTH_LOG2 = 4, 16 entries per FIFO).
// Inputs change 1 ns after the rising edge; outputs are sampled at that point,
// well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_terminal_fifo;

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic [7:0] usb_out_data;
    logic       usb_out_valid;
    logic       usb_out_ready;
    logic [7:0] usb_in_data;
    logic       usb_in_valid;
    logic       usb_in_ready;
    logic       cpu_rd;
    logic [7:0] cpu_rx_data;
    logic       cpu_rx_valid;
    logic       cpu_wr;
    logic [7:0] cpu_tx_data;
    logic       cpu_tx_ready;
    logic [4:0] rx_level;
    logic [4:0] tx_level;
    logic       err_clr;
    logic       rx_underrun;
    logic       tx_overrun;

    int n_checks;
    int n_fail;

    terminal_fifo #(.DEPTH_LOG2(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .usb_out_data  (usb_out_data),
        .usb_out_valid (usb_out_valid),
        .usb_out_ready (usb_out_ready),
        .usb_in_data   (usb_in_data),
        .usb_in_valid  (usb_in_valid),
        .usb_in_ready  (usb_in_ready),
        .cpu_rd        (cpu_rd),
        .cpu_rx_data   (cpu_rx_data),
        .cpu_rx_valid  (cpu_rx_valid),
        .cpu_wr        (cpu_wr),
        .cpu_tx_data   (cpu_tx_data),
        .cpu_tx_ready  (cpu_tx_ready),
        .rx_level      (rx_level),
        .tx_level      (tx_level),
        .err_clr       (err_clr),
        .rx_underrun   (rx_underrun),
        .tx_overrun    (tx_overrun)
    );

    // Clock generator, held low until enabled so reset can be checked clockless
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        clk           = 1'b0;
        clk_en        = 1'b0;
        reset         = 1'b0;
        usb_out_data  = 8'h00;
        usb_out_valid = 1'b0;
        usb_in_ready  = 1'b0;
        cpu_rd        = 1'b0;
        cpu_wr        = 1'b0;
        cpu_tx_data   = 8'h00;
        err_clr       = 1'b0;

        // ---- Reset state, no clock running ----
        #3;
        reset = 1'b1;
        #1;
        check("rst_usb_out_ready", 32'(usb_out_ready), 32'h1);
        check("rst_cpu_tx_ready",  32'(cpu_tx_ready),  32'h1);
        check("rst_cpu_rx_valid",  32'(cpu_rx_valid),  32'h0);
        check("rst_usb_in_valid",  32'(usb_in_valid),  32'h0);
        check("rst_cpu_rx_data",   32'(cpu_rx_data),   32'h0);
        check("rst_usb_in_data",   32'(usb_in_data),   32'h0);
        check("rst_rx_level",      32'(rx_level),      32'h0);
        check("rst_tx_level",      32'(tx_level),      32'h0);
        check("rst_rx_underrun",   32'(rx_underrun),   32'h0);
        check("rst_tx_overrun",    32'(tx_overrun),    32'h0);
        clk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // ---- RX fill 0x01..0x10 with valid held high ----
        usb_out_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            usb_out_data = 8'(i + 1);
            tick();
            if (i == 0) begin
                check("rx_first_valid", 32'(cpu_rx_valid), 32'h1);
                check("rx_first_head",  32'(cpu_rx_data),  32'h01);
            end
            if (i == 14) check("rx_ready_at_15", 32'(usb_out_ready), 32'h1);
        end
        check("rx_full_ready", 32'(usb_out_ready), 32'h0);
        check("rx_full_level", 32'(rx_level),      32'd16);
        usb_out_data = 8'h99;
        tick();
        check("rx_full_hold_level", 32'(rx_level), 32'd16);
        usb_out_valid = 1'b0;

        // ---- RX drain, one pop per cycle ----
        for (int i = 0; i < 16; i++) begin
            check("rx_drain_data", 32'(cpu_rx_data), 32'(i + 1));
            cpu_rd = 1'b1;
            tick();
            if (i == 0) check("rx_ready_after_pop", 32'(usb_out_ready), 32'h1);
        end
        cpu_rd = 1'b0;
        check("rx_drain_level", 32'(rx_level),     32'h0);
        check("rx_drain_valid", 32'(cpu_rx_valid), 32'h0);
        check("rx_drain_head0", 32'(cpu_rx_data),  32'h0);
        check("rx_no_underrun", 32'(rx_underrun),  32'h0);

        // ---- RX wrap-around: push 10, pop 10, push 12 ----
        usb_out_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            usb_out_data = 8'(8'h20 + i);
            tick();
        end
        usb_out_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("wrap_first_data", 32'(cpu_rx_data), 32'(8'h20 + i));
            cpu_rd = 1'b1;
            tick();
        end
        cpu_rd = 1'b0;
        usb_out_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            usb_out_data = 8'(8'hA0 + i);
            tick();
        end
        usb_out_valid = 1'b0;
        check("wrap_level", 32'(rx_level), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check("wrap_data", 32'(cpu_rx_data), 32'(8'hA0 + i));
            cpu_rd = 1'b1;
            tick();
        end
        cpu_rd = 1'b0;
        check("wrap_empty", 32'(rx_level), 32'h0);

        // ---- RX simultaneous push and pop at level 5 ----
        usb_out_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            usb_out_data = 8'(8'h30 + i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            usb_out_data = 8'(8'h35 + i);
            cpu_rd = 1'b1;
            check("sim_head", 32'(cpu_rx_data), 32'(8'h30 + i));
            tick();
            check("sim_level", 32'(rx_level), 32'd5);
        end
        usb_out_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("sim_tail", 32'(cpu_rx_data), 32'(8'h44 + i));
            tick();
        end
        cpu_rd = 1'b0;
        check("sim_empty", 32'(rx_level), 32'h0);

        // ---- TX overrun: 17 writes with the in-stream stalled ----
        usb_in_ready = 1'b0;
        cpu_wr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cpu_tx_data = 8'(8'h41 + i);
            tick();
            if (i == 0) begin
                check("tx_first_valid", 32'(usb_in_valid), 32'h1);
                check("tx_first_head",  32'(usb_in_data),  32'h41);
            end
            if (i == 15) begin
                check("tx_full_ready",   32'(cpu_tx_ready), 32'h0);
                check("tx_no_ovr_at_16", 32'(tx_overrun),   32'h0);
            end
        end
        cpu_wr = 1'b0;
        check("tx_ovr_level", 32'(tx_level),   32'd16);
        check("tx_ovr_flag",  32'(tx_overrun), 32'h1);
        usb_in_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("tx_drain_valid", 32'(usb_in_valid), 32'h1);
            check("tx_drain_data",  32'(usb_in_data),  32'(8'h41 + i));
            tick();
        end
        check("tx_drain_empty", 32'(usb_in_valid), 32'h0);
        check("tx_drain_level", 32'(tx_level),     32'h0);
        check("tx_drain_head0", 32'(usb_in_data),  32'h0);
        check("tx_ovr_sticky",  32'(tx_overrun),   32'h1);

        // ---- Underrun and clear ----
        cpu_rd = 1'b1;
        tick();
        check("udr_flag",  32'(rx_underrun), 32'h1);
        check("udr_level", 32'(rx_level),    32'h0);
        err_clr = 1'b1;
        tick();
        check("udr_set_wins", 32'(rx_underrun), 32'h1);
        check("ovr_cleared",  32'(tx_overrun),  32'h0);
        cpu_rd = 1'b0;
        tick();
        err_clr = 1'b0;
        check("udr_cleared", 32'(rx_underrun), 32'h0);

        // ---- Empty RX: push and read together -> push lands, underrun set ----
        usb_out_valid = 1'b1;
        usb_out_data  = 8'h5A;
        cpu_rd        = 1'b1;
        tick();
        usb_out_valid = 1'b0;
        cpu_rd        = 1'b0;
        check("empty_pp_level", 32'(rx_level),    32'h1);
        check("empty_pp_head",  32'(cpu_rx_data), 32'h5A);
        check("empty_pp_udr",   32'(rx_underrun), 32'h1);

        // ---- Reset mid-transfer discards both sides ----
        usb_in_ready = 1'b0;
        cpu_wr       = 1'b1;
        cpu_tx_data  = 8'h77;
        tick();
        cpu_wr = 1'b0;
        check("pre_rst_tx_level", 32'(tx_level), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rx_level", 32'(rx_level),     32'h0);
        check("mid_rst_tx_level", 32'(tx_level),     32'h0);
        check("mid_rst_rx_valid", 32'(cpu_rx_valid), 32'h0);
        check("mid_rst_in_data",  32'(usb_in_data),  32'h0);
        check("mid_rst_udr",      32'(rx_underrun),  32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(usb_out_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/terminal_fifo.md
# terminal_fifo

Dual byte FIFO between the USB-CDC terminal core and the j1 IO bus. The receive side buffers host-to-target bytes from the CDC out-stream until the CPU reads them. The transmit side buffers CPU-written bytes until the CDC in-stream accepts them. Both sides run in the 12 MHz application clock domain and add occupancy levels and sticky error flags to the terminal status port.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: log2 of the entry count per FIFO, giving 16 bytes each; legal range 1..8.

Ports:
- `clk`  in  1  application clock (12 MHz)
- `reset`  in  1  asynchronous, active-high reset
- `usb_out_data`  in  8  byte from the CDC out-stream
- `usb_out_valid`  in  1  CDC out-stream valid
- `usb_out_ready`  out  1  RX FIFO not full
- `usb_in_data`  out  8  TX FIFO head byte; 0 when TX is empty
- `usb_in_valid`  out  1  TX FIFO not empty
- `usb_in_ready`  in  1  CDC in-stream ready
- `cpu_rd`  in  1  one-cycle pop strobe (IO read of the terminal data port)
- `cpu_rx_data`  out  8  RX FIFO head byte; 0 when RX is empty
- `cpu_rx_valid`  out  1  RX FIFO not empty
- `cpu_wr`  in  1  one-cycle push strobe (IO write of the terminal data port)
- `cpu_tx_data`  in  8  byte to transmit
- `cpu_tx_ready`  out  1  TX FIFO not full
- `rx_level`  out  DEPTH_LOG2+1  RX occupancy, 0..DEPTH
- `tx_level`  out  DEPTH_LOG2+1  TX occupancy, 0..DEPTH
- `err_clr`  in  1  clears both sticky flags
- `rx_underrun`  out  1  sticky flag: `cpu_rd` arrived while RX was empty
- `tx_overrun`  out  1  sticky flag: `cpu_wr` arrived while TX was full

## Operation
- DEPTH = 2^DEPTH_LOG2. Each FIFO has a register array, a DEPTH_LOG2-bit write pointer, a DEPTH_LOG2-bit read pointer and a DEPTH_LOG2+1-bit level counter. Both pointers wrap modulo DEPTH.
- Full means level == DEPTH. Empty means level == 0. The level is the only source of full and empty; pointer equality is never used.
- Both FIFOs are first-word-fall-through. Head data is a combinational read at the read pointer, gated to 0 when the FIFO is empty.
- RX push happens when `usb_out_valid & usb_out_ready`. `usb_out_ready` = !rx_full, decoded combinationally from the registered level.
- RX pop happens when `cpu_rd & cpu_rx_valid`. The CPU samples `cpu_rx_data` in the same cycle as the strobe, before the pop takes effect.
- TX push happens when `cpu_wr & cpu_tx_ready`. TX pop happens when `usb_in_valid & usb_in_ready`.
- Level update per FIFO: level <= level + push - pop. When push and pop occur in the same cycle, the level is unchanged and both pointers advance.
- Simultaneous push and pop when full: cannot occur on RX, because ready is low. On TX, `cpu_wr` is refused and `tx_overrun` is set; the pop still proceeds.
- Simultaneous push and pop when empty: the pop is not performed because valid is low. The push completes and the level goes to 1.
- `cpu_rd` while RX is empty: no state change other than setting `rx_underrun`.
- `cpu_wr` while TX is full: the byte is dropped and `tx_overrun` is set.
- Sticky flags are cleared by `err_clr`. If set and clear occur in the same cycle, set wins.
- The block has no upstream backpressure on the CPU side; software polls `cpu_tx_ready` and `cpu_rx_valid` through the status port.

## Timing
- Reset (asynchronous assert; release is synchronous to the design's reset synchroniser) clears:
  - pointers and levels to 0
  - `rx_underrun` and `tx_overrun` to 0
- Reset values of the outputs:
  - `usb_out_ready` = 1, `cpu_tx_ready` = 1
  - `cpu_rx_valid` = 0, `usb_in_valid` = 0
  - `cpu_rx_data` = 0, `usb_in_data` = 0
- Array contents are not reset.
- Reset mid-transfer discards all buffered bytes on both sides. No partial state survives.
- Push-to-visible latency is 1 cycle. A byte accepted at edge N gives valid = 1 and head = that byte in the cycle after N.
- A pop at edge N presents the next head in the cycle after N. A full FIFO sustains one pop per cycle.
- Ready and valid after a full or empty transition change in the cycle following the causing edge. There is no combinational path from `usb_out_valid` to `usb_out_ready`, or from `usb_in_ready` to `usb_in_valid`.
- Throughput is one push plus one pop per FIFO per cycle.

## Test plan
- **Reset state:** assert `reset` mid-cycle with no clock -> all outputs immediately take their reset values, including `usb_out_ready` = 1, `rx_level` = 0 and `cpu_rx_data` = 0x00.
- **RX fill and drain:** push 0x01..0x10 with `usb_out_valid` held high -> `usb_out_ready` drops after the 16th byte and `rx_level` = 16. Then 16 `cpu_rd` strobes -> bytes 0x01..0x10 come out in order and `rx_level` returns to 0.
- **RX wrap-around:** push 10 bytes, pop 10, push 12 bytes (0xA0..0xAB) -> the pointers wrap, and pops return 0xA0..0xAB in order.
- **RX simultaneous push and pop:** at level 5, push and pop in the same cycle for 20 cycles -> the level stays 5 and the data order is preserved.
- **TX overrun:** with `usb_in_ready` = 0, issue 17 `cpu_wr` of 0x41..0x51 -> `tx_level` = 16 and `tx_overrun` = 1; byte 0x51 is never emitted. Release `usb_in_ready` -> bytes 0x41..0x50 are emitted and `usb_in_valid` drops.
- **Underrun and clear:** `cpu_rd` while RX is empty -> `rx_underrun` = 1 and the level stays 0. Then `err_clr` together with a second empty `cpu_rd` -> the flag stays 1. `err_clr` alone -> the flag becomes 0.
